// File: rtl/ptn_gen_multi.sv
// Multi-pattern video generator: own H/V timing, six test patterns, frame-boundary
// pattern switching and a two-stage registered pipeline with aligned sync outputs.
module ptn_gen_multi #(
  parameter int H_ACTIVE    = 1920,
  parameter int V_ACTIVE    = 1080,
  parameter int H_TOTAL     = 2400,
  parameter int V_TOTAL     = 1400,
  parameter int CNT_W       = 12,
  parameter int PIXEL_W     = 8,
  parameter int NUM_BANDS   = 10,
  parameter int RAMP_SHIFT  = 3,
  parameter int CHECK_SHIFT = 6,
  parameter int MOVE_STEP   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [2:0]             i_ptn_sel,
  input  logic [3*PIXEL_W-1:0]   i_solid_rgb,
  output logic [PIXEL_W-1:0]     o_R_data,
  output logic [PIXEL_W-1:0]     o_G_data,
  output logic [PIXEL_W-1:0]     o_B_data,
  output logic                   o_VSync,
  output logic                   o_HSync,
  output logic                   o_DE,
  output logic                   o_frame_start,
  output logic [2:0]             o_ptn_active
);

  localparam logic [CNT_W-1:0]   H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]   V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]   H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]   V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]   BH_M1    = CNT_W'(V_ACTIVE / NUM_BANDS - 1);
  localparam logic [CNT_W-1:0]   NB_M1    = CNT_W'(NUM_BANDS - 1);
  localparam logic [CNT_W-1:0]   BW_M1    = CNT_W'(H_ACTIVE / 8 - 1);
  localparam logic [CNT_W-1:0]   BAR_W    = CNT_W'(1 << CHECK_SHIFT);
  localparam logic [CNT_W-1:0]   MSTEP    = CNT_W'(MOVE_STEP);
  localparam logic [CNT_W-1:0]   RAMP_MAX = CNT_W'((1 << PIXEL_W) - 1);
  localparam logic [PIXEL_W-1:0] PMAX     = '1;
  localparam logic [PIXEL_W-1:0] STEP     = PIXEL_W'(((1 << PIXEL_W) - 1) / (NUM_BANDS - 1));

  logic [CNT_W-1:0]     hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CNT_W-1:0]     line_q, line_d, band_q, band_d;
  logic [CNT_W-1:0]     bpx_q, bpx_d, off_q, off_d, offn_q, offn_d;
  logic [2:0]           bar_q, bar_d, ptn_q, ptn_d;
  logic [PIXEL_W-1:0]   lvl_q, lvl_d;
  logic [3*PIXEL_W-1:0] solid_q, solid_d;
  logic [CNT_W:0]       offn_sum;
  logic                 frame_b;

  logic [2:0]           ptn_e;
  logic [CNT_W-1:0]     off_e, rsh, mdiff;
  logic [PIXEL_W-1:0]   ramp;
  logic [3*PIXEL_W-1:0] solid_e;

  logic                 s1_de_q, s1_hs_q, s1_vs_q, s1_fs_q, s1_chk_q, s1_mbar_q;
  logic [2:0]           s1_ptn_q, s1_bar_q;
  logic [PIXEL_W-1:0]   s1_lvl_q, s1_ramp_q;
  logic [3*PIXEL_W-1:0] s1_solid_q;

  logic [3*PIXEL_W-1:0] rgb_d, rgb_q;
  logic                 vs_q, hs_q, de_q, fs_q;
  logic [2:0]           pa_q;

  // Timing counters plus the divider-free band and colour-bar trackers that follow them.
  always_comb begin
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    line_d   = line_q;
    band_d   = band_q;
    lvl_d    = lvl_q;
    bpx_d    = bpx_q;
    bar_d    = bar_q;
    ptn_d    = ptn_q;
    solid_d  = solid_q;
    off_d    = off_q;
    offn_d   = offn_q;
    frame_b  = i_en && (hcnt_q == '0) && (vcnt_q == '0);
    offn_sum = {1'b0, offn_q} + {1'b0, MSTEP};
    if (!i_en) begin
      hcnt_d = '0;
      vcnt_d = '0;
      line_d = '0;
      band_d = '0;
      lvl_d  = '0;
      bpx_d  = '0;
      bar_d  = '0;
    end else begin
      if (frame_b) begin
        ptn_d   = i_ptn_sel;
        solid_d = i_solid_rgb;
        off_d   = offn_q;
        offn_d  = (offn_sum >= {1'b0, H_ACT}) ? CNT_W'(offn_sum - {1'b0, H_ACT})
                                               : offn_sum[CNT_W-1:0];
      end
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        bpx_d  = '0;
        bar_d  = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d = '0;
          line_d = '0;
          band_d = '0;
          lvl_d  = '0;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
          if (vcnt_q < V_ACT) begin
            if (line_q == BH_M1) begin
              line_d = '0;
              if (band_q < NB_M1) begin
                band_d = band_q + 1'b1;
                lvl_d  = (band_q + 1'b1 == NB_M1) ? PMAX : lvl_q + STEP;
              end
            end else begin
              line_d = line_q + 1'b1;
            end
          end
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
        if (bpx_q == BW_M1) begin
          bpx_d = '0;
          if (bar_q != 3'd7) bar_d = bar_q + 1'b1;
        end else begin
          bpx_d = bpx_q + 1'b1;
        end
      end
    end
  end

  // The boundary pixel itself must already use the newly selected values.
  assign ptn_e   = frame_b ? i_ptn_sel   : ptn_q;
  assign off_e   = frame_b ? offn_q      : off_q;
  assign solid_e = frame_b ? i_solid_rgb : solid_q;
  assign rsh     = hcnt_q >> RAMP_SHIFT;
  assign ramp    = (rsh > RAMP_MAX) ? PMAX : rsh[PIXEL_W-1:0];
  assign mdiff   = (hcnt_q >= off_e) ? hcnt_q - off_e : hcnt_q + H_ACT - off_e;

  always_comb begin
    rgb_d = '0;
    if (s1_de_q) begin
      case (s1_ptn_q)
        3'd0:    rgb_d = {3{s1_lvl_q}};
        3'd1:    rgb_d = {3{s1_ramp_q}};
        3'd2:    rgb_d = {{PIXEL_W{~s1_bar_q[1]}}, {PIXEL_W{~s1_bar_q[2]}}, {PIXEL_W{~s1_bar_q[0]}}};
        3'd3:    rgb_d = {3*PIXEL_W{s1_chk_q}};
        3'd4:    rgb_d = s1_solid_q;
        3'd5:    rgb_d = {3*PIXEL_W{s1_mbar_q}};
        default: rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      line_q     <= '0;
      band_q     <= '0;
      lvl_q      <= '0;
      bpx_q      <= '0;
      bar_q      <= '0;
      ptn_q      <= '0;
      solid_q    <= '0;
      off_q      <= '0;
      offn_q     <= '0;
      s1_de_q    <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_fs_q    <= 1'b0;
      s1_chk_q   <= 1'b0;
      s1_mbar_q  <= 1'b0;
      s1_ptn_q   <= '0;
      s1_bar_q   <= '0;
      s1_lvl_q   <= '0;
      s1_ramp_q  <= '0;
      s1_solid_q <= '0;
      rgb_q      <= '0;
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      pa_q       <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      line_q  <= line_d;
      band_q  <= band_d;
      lvl_q   <= lvl_d;
      bpx_q   <= bpx_d;
      bar_q   <= bar_d;
      ptn_q   <= ptn_d;
      solid_q <= solid_d;
      off_q   <= off_d;
      offn_q  <= offn_d;
      if (!i_en) begin
        s1_de_q    <= 1'b0;
        s1_hs_q    <= 1'b0;
        s1_vs_q    <= 1'b0;
        s1_fs_q    <= 1'b0;
        s1_chk_q   <= 1'b0;
        s1_mbar_q  <= 1'b0;
        s1_ptn_q   <= '0;
        s1_bar_q   <= '0;
        s1_lvl_q   <= '0;
        s1_ramp_q  <= '0;
        s1_solid_q <= '0;
        rgb_q      <= '0;
        vs_q       <= 1'b0;
        hs_q       <= 1'b0;
        de_q       <= 1'b0;
        fs_q       <= 1'b0;
        pa_q       <= '0;
      end else begin
        s1_de_q    <= (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        s1_hs_q    <= hcnt_q >= H_ACT;
        s1_vs_q    <= vcnt_q >= V_ACT;
        s1_fs_q    <= frame_b;
        s1_chk_q   <= hcnt_q[CHECK_SHIFT] ^ vcnt_q[CHECK_SHIFT];
        s1_mbar_q  <= mdiff < BAR_W;
        s1_ptn_q   <= ptn_e;
        s1_bar_q   <= bar_q;
        s1_lvl_q   <= lvl_q;
        s1_ramp_q  <= ramp;
        s1_solid_q <= solid_e;
        rgb_q      <= rgb_d;
        vs_q       <= s1_vs_q;
        hs_q       <= s1_hs_q;
        de_q       <= s1_de_q;
        fs_q       <= s1_fs_q;
        pa_q       <= s1_ptn_q;
      end
    end
  end

  assign o_R_data      = rgb_q[3*PIXEL_W-1:2*PIXEL_W];
  assign o_G_data      = rgb_q[2*PIXEL_W-1:PIXEL_W];
  assign o_B_data      = rgb_q[PIXEL_W-1:0];
  assign o_VSync       = vs_q;
  assign o_HSync       = hs_q;
  assign o_DE          = de_q;
  assign o_frame_start = fs_q;
  assign o_ptn_active  = pa_q;

endmodule
